aes_cmd_sequencer: RTL



---
 rtl/aes_cmd_sequencer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/aes_cmd_sequencer.sv
// aes_cmd_sequencer: turns an AES job (key/src/dst addresses, block count) into bus transactions.
//   clk, rst_n                      : clock (rising edge), asynchronous active-low reset
//   job_valid/job_ready + job_*     : job request handshake; mode, block count, key/src/dst base addresses
//   tx_valid/tx_ready + tx fields   : outgoing transaction handshake; opcode, source_id, dest_id, encdec, addr
//   ack_valid/ack_ready, module_source_id : completion acks from bus modules
//   busy, done, err, blocks_done    : job status; done/err are one-cycle pulses
module aes_cmd_sequencer #(
    parameter logic [1:0]  MEM_ID      = 2'b00,
    parameter logic [1:0]  AES_ID      = 2'b10,
    parameter logic [15:0] ACK_TIMEOUT = 16'd4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic        job_encdec,
    input  logic [7:0]  job_nblocks,
    input  logic [23:0] job_key_addr,
    input  logic [23:0] job_src_addr,
    input  logic [23:0] job_dst_addr,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [1:0]  opcode,
    output logic [1:0]  source_id,
    output logic [1:0]  dest_id,
    output logic        encdec,
    output logic [23:0] addr,
    input  logic        ack_valid,
    output logic        ack_ready,
    input  logic [1:0]  module_source_id,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  blocks_done
);
    typedef enum logic [2:0] {IDLE, T_KEY, T_TEXT, T_HASH, T_WRES, W_ACK} state_t;
    localparam logic [1:0] OP_KEY  = 2'b00;
    localparam logic [1:0] OP_TEXT = 2'b01;
    localparam logic [1:0] OP_HASH = 2'b11;
    localparam logic [1:0] OP_WRES = 2'b10;
    state_t      state_q, state_d;
    logic        job_ready_q, job_ready_d;
    logic        tx_valid_q, tx_valid_d;
    logic [1:0]  opcode_q, opcode_d;
    logic [1:0]  source_id_q, source_id_d;
    logic [1:0]  dest_id_q, dest_id_d;
    logic        encdec_q, encdec_d;
    logic [23:0] addr_q, addr_d;
    logic        ack_ready_q, ack_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  blocks_done_q, blocks_done_d;
    logic [7:0]  nblocks_q, nblocks_d;
    logic [23:0] src_q, src_d;
    logic [23:0] dst_q, dst_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tx_acc, ack_hit;
    logic [7:0]  bd_inc;
    // Byte offset of block b; the 24-bit sum with a base address wraps naturally.
    function automatic logic [23:0] blk_off(input logic [7:0] b);
        return {12'd0, b, 4'd0};
    endfunction
    assign tx_acc = tx_valid_q && tx_ready;
    // Only acks from the AES engine count; others are accepted and dropped.
    assign ack_hit = ack_valid && ack_ready_q && (module_source_id == AES_ID);
    assign bd_inc = blocks_done_q + 8'd1;
    always_comb begin
        state_d       = state_q;
        job_ready_d   = job_ready_q;
        tx_valid_d    = tx_valid_q;
        opcode_d      = opcode_q;
        source_id_d   = source_id_q;
        dest_id_d     = dest_id_q;
        encdec_d      = encdec_q;
        addr_d        = addr_q;
        ack_ready_d   = ack_ready_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        blocks_done_d = blocks_done_q;
        nblocks_d     = nblocks_q;
        src_d         = src_q;
        dst_d         = dst_q;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                // job_ready is held low for the cycle a done/err pulse is out.
                job_ready_d = 1'b1;
                if (job_valid && job_ready_q) begin
                    job_ready_d   = 1'b0;
                    encdec_d      = job_encdec;
                    nblocks_d     = job_nblocks;
                    src_d         = job_src_addr;
                    dst_d         = job_dst_addr;
                    blocks_done_d = 8'd0;
                    if (job_nblocks == 8'd0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = T_KEY;
                        busy_d      = 1'b1;
                        tx_valid_d  = 1'b1;
                        opcode_d    = OP_KEY;
                        source_id_d = MEM_ID;
                        dest_id_d   = AES_ID;
                        addr_d      = job_key_addr;
                    end
                end
            end
            T_KEY: begin
                if (tx_acc) begin
                    state_d  = T_TEXT;
                    opcode_d = OP_TEXT;
                    addr_d   = src_q + blk_off(blocks_done_q);
                end
            end
            T_TEXT: begin
                if (tx_acc) begin
                    state_d  = T_HASH;
                    opcode_d = OP_HASH;
                    addr_d   = 24'd0;
                end
            end
            T_HASH: begin
                if (tx_acc) begin
                    state_d     = T_WRES;
                    opcode_d    = OP_WRES;
                    source_id_d = AES_ID;
                    dest_id_d   = MEM_ID;
                    addr_d      = dst_q + blk_off(blocks_done_q);
                end
            end
            T_WRES: begin
                if (tx_acc) begin
                    state_d     = W_ACK;
                    tx_valid_d  = 1'b0;
                    ack_ready_d = 1'b1;
                    cnt_d       = 16'd0;
                end
            end
            W_ACK: begin
                cnt_d = cnt_q + 16'd1;
                // An AES ack takes priority over a timeout in the same cycle.
                if (ack_hit) begin
                    blocks_done_d = bd_inc;
                    ack_ready_d   = 1'b0;
                    if (bd_inc == nblocks_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = T_TEXT;
                        tx_valid_d  = 1'b1;
                        opcode_d    = OP_TEXT;
                        source_id_d = MEM_ID;
                        dest_id_d   = AES_ID;
                        addr_d      = src_q + blk_off(bd_inc);
                    end
                end else if (cnt_q == ACK_TIMEOUT - 16'd1) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    ack_ready_d = 1'b0;
                    err_d       = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                busy_d      = 1'b0;
                tx_valid_d  = 1'b0;
                ack_ready_d = 1'b0;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            job_ready_q   <= 1'b0;
            tx_valid_q    <= 1'b0;
            opcode_q      <= 2'b00;
            source_id_q   <= 2'b00;
            dest_id_q     <= 2'b00;
            encdec_q      <= 1'b0;
            addr_q        <= 24'd0;
            ack_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            blocks_done_q <= 8'd0;
            nblocks_q     <= 8'd0;
            src_q         <= 24'd0;
            dst_q         <= 24'd0;
            cnt_q         <= 16'd0;
        end else begin
            state_q       <= state_d;
            job_ready_q   <= job_ready_d;
            tx_valid_q    <= tx_valid_d;
            opcode_q      <= opcode_d;
            source_id_q   <= source_id_d;
            dest_id_q     <= dest_id_d;
            encdec_q      <= encdec_d;
            addr_q        <= addr_d;
            ack_ready_q   <= ack_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            blocks_done_q <= blocks_done_d;
            nblocks_q     <= nblocks_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            cnt_q         <= cnt_d;
        end
    end
    assign job_ready   = job_ready_q;
    assign tx_valid    = tx_valid_q;
    assign opcode      = opcode_q;
    assign source_id   = source_id_q;
    assign dest_id     = dest_id_q;
    assign encdec      = encdec_q;
    assign addr        = addr_q;
    assign ack_ready   = ack_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign blocks_done = blocks_done_q;
endmodule
